axis_byte_source: RTL and testbench



---
 rtl/axis_byte_source.sv | 122 ++++++++++++
 tb/tb_axis_byte_source.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_source.sv
// Programmable AXI4-Stream byte-burst source: length, seed and inter-beat gap latched on start.
// Optional build macro AXIS_BYTE_SOURCE_LFSR_EN swaps the incrementing data pattern for an 8-bit Galois LFSR.
module axis_byte_source #(
  parameter int DW = 8,
  parameter int CW = 16,
  parameter int GW = 8
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic [GW-1:0] gap,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt,
  output logic          tvalid,
  input  logic          tready,
  output logic [DW-1:0] tdata
);

  // state | meaning
  // IDLE  | waiting for start; cnt holds the last burst's count
  // SEND  | tvalid high, waiting for handshake
  // GAP   | tvalid low, counting down inter-beat idle cycles
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state;
  logic [CW-1:0] remaining;
  logic [GW-1:0] gap_r;
  logic [GW-1:0] gap_cnt;

`ifdef AXIS_BYTE_SOURCE_LFSR_EN
  if (DW != 8) begin : g_dw_check
    $error("axis_byte_source: LFSR build requires DW == 8");
  end

  function automatic logic [DW-1:0] next_data(input logic [DW-1:0] d);
    return (d >> 1) ^ (d[0] ? DW'(8'hB8) : DW'(0));
  endfunction

  // An all-zero LFSR state would lock up, so zero seeds start at 1.
  function automatic logic [DW-1:0] first_data(input logic [DW-1:0] s);
    return (s == '0) ? DW'(1) : s;
  endfunction
`else
  function automatic logic [DW-1:0] next_data(input logic [DW-1:0] d);
    return d + DW'(1);
  endfunction

  function automatic logic [DW-1:0] first_data(input logic [DW-1:0] s);
    return s;
  endfunction
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      remaining <= '0;
      gap_r     <= '0;
      gap_cnt   <= '0;
      tdata     <= '0;
      tvalid    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (len != '0) begin
              remaining <= len;
              gap_r     <= gap;
              tdata     <= first_data(seed);
              tvalid    <= 1'b1;
              busy      <= 1'b1;
              state     <= SEND;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (tready) begin
            cnt   <= cnt + CW'(1);
            tdata <= next_data(tdata);
            if (remaining == CW'(1)) begin
              tvalid <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              remaining <= remaining - CW'(1);
              if (gap_r != '0) begin
                tvalid  <= 1'b0;
                gap_cnt <= gap_r;
                state   <= GAP;
              end
            end
          end
        end
        GAP: begin
          // Terminal count at 1 so tvalid is low for exactly gap_r cycles.
          if (gap_cnt == GW'(1)) begin
            tvalid <= 1'b1;
            state  <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          tvalid <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_byte_source.sv
// Directed self-checking bench for axis_byte_source (both data-pattern builds).
module tb_axis_byte_source;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [15:0] len;
  logic [7:0]  gap;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [15:0] cnt;
  logic        tvalid;
  logic        tready;
  logic [7:0]  tdata;

  int passed = 0;
  int total  = 0;

  axis_byte_source #(.DW(8), .CW(16), .GW(8)) dut (
    .aclk(aclk), .areset(areset), .start(start), .len(len), .gap(gap),
    .seed(seed), .busy(busy), .done(done), .cnt(cnt), .tvalid(tvalid),
    .tready(tready), .tdata(tdata)
  );

  always #5 aclk = ~aclk;

`ifdef AXIS_BYTE_SOURCE_LFSR_EN
  function automatic logic [7:0] model_next(input logic [7:0] d);
    return (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
  endfunction
  function automatic logic [7:0] model_first(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction
`else
  function automatic logic [7:0] model_next(input logic [7:0] d);
    return d + 8'h01;
  endfunction
  function automatic logic [7:0] model_first(input logic [7:0] s);
    return s;
  endfunction
`endif

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic launch(input logic [15:0] l, input logic [7:0] g, input logic [7:0] s);
    len = l; gap = g; seed = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; len = '0; gap = '0; seed = '0; tready = 1'b0;
    #2;
    total++;
    if ({tvalid, busy, done, cnt, tdata} !== 27'd0)
      $display("FAIL reset: tvalid=%b busy=%b done=%b cnt=%0d tdata=%h, want all zero",
               tvalid, busy, done, cnt, tdata);
    else passed++;
    #10 areset = 1'b0;
    tick();
  endtask

  task automatic test_incr_wrap();
    logic [7:0] exp;
    tready = 1'b1;
    launch(16'd4, 8'd0, 8'hFE);
    exp = model_first(8'hFE);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({tvalid, busy, done, tdata} !== {3'b110, exp})
        $display("FAIL wrap_beat%0d: tvalid=%b busy=%b done=%b tdata=%h, want 1 1 0 %h",
                 i, tvalid, busy, done, tdata, exp);
      else passed++;
      exp = model_next(exp);
      tick();
    end
    total++;
    if ({tvalid, busy, done, cnt} !== {3'b001, 16'd4})
      $display("FAIL wrap_done: tvalid=%b busy=%b done=%b cnt=%0d, want 0 0 1 4",
               tvalid, busy, done, cnt);
    else passed++;
    tick();
    total++;
    if ({done, cnt} !== {1'b0, 16'd4})
      $display("FAIL wrap_hold: done=%b cnt=%0d, want 0 4", done, cnt);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    tready = 1'b0;
    launch(16'd3, 8'd0, 8'h10);
    exp = model_first(8'h10);
    for (int c = 1; c <= 3; c++) begin
      total++;
      if ({tvalid, tdata, cnt} !== {1'b1, exp, 16'd0})
        $display("FAIL bp_stall_c%0d: tvalid=%b tdata=%h cnt=%0d, want 1 %h 0",
                 c, tvalid, tdata, cnt, exp);
      else passed++;
      tick();
    end
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({tvalid, tdata, cnt} !== {1'b1, exp, 16'(i)})
        $display("FAIL bp_beat%0d: tvalid=%b tdata=%h cnt=%0d, want 1 %h %0d",
                 i, tvalid, tdata, cnt, exp, i);
      else passed++;
      exp = model_next(exp);
      tick();
    end
    total++;
    if ({tvalid, done, cnt} !== {2'b01, 16'd3})
      $display("FAIL bp_done: tvalid=%b done=%b cnt=%0d, want 0 1 3", tvalid, done, cnt);
    else passed++;
  endtask

  task automatic test_gap();
    logic [6:0] pat = 7'b1001001;
    logic [7:0] exp;
    tready = 1'b1;
    launch(16'd3, 8'd2, 8'h00);
    exp = model_first(8'h00);
    for (int c = 0; c < 7; c++) begin
      total++;
      if (tvalid !== pat[6-c] || busy !== 1'b1 || (pat[6-c] && tdata !== exp))
        $display("FAIL gap_c%0d: tvalid=%b busy=%b tdata=%h, want %b 1 %h",
                 c + 1, tvalid, busy, tdata, pat[6-c], exp);
      else passed++;
      if (pat[6-c]) exp = model_next(exp);
      tick();
    end
    total++;
    if ({tvalid, busy, done, cnt} !== {3'b001, 16'd3})
      $display("FAIL gap_done: tvalid=%b busy=%b done=%b cnt=%0d, want 0 0 1 3",
               tvalid, busy, done, cnt);
    else passed++;
    // start on the done cycle must be accepted
    launch(16'd1, 8'd0, 8'hAA);
    total++;
    if ({tvalid, busy, tdata} !== {2'b11, model_first(8'hAA)})
      $display("FAIL start_on_done: tvalid=%b busy=%b tdata=%h, want 1 1 %h",
               tvalid, busy, tdata, model_first(8'hAA));
    else passed++;
    tick();
    total++;
    if ({done, cnt} !== {1'b1, 16'd1})
      $display("FAIL start_on_done_end: done=%b cnt=%0d, want 1 1", done, cnt);
    else passed++;
    tick();
  endtask

  task automatic test_zero_len_and_busy_start();
    logic [7:0] exp;
    tready = 1'b1;
    launch(16'd0, 8'd0, 8'h55);
    total++;
    if ({tvalid, busy, done, cnt} !== {3'b001, 16'd0})
      $display("FAIL zero_len: tvalid=%b busy=%b done=%b cnt=%0d, want 0 0 1 0",
               tvalid, busy, done, cnt);
    else passed++;
    tick();
    total++;
    if ({tvalid, done} !== 2'b00)
      $display("FAIL zero_len_after: tvalid=%b done=%b, want 0 0", tvalid, done);
    else passed++;

    launch(16'd5, 8'd0, 8'h40);
    exp = model_first(8'h40);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        len = 16'd1; gap = 8'd3; seed = 8'h80; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      total++;
      if ({tvalid, busy, tdata} !== {2'b11, exp})
        $display("FAIL busy_start_beat%0d: tvalid=%b busy=%b tdata=%h, want 1 1 %h",
                 i, tvalid, busy, tdata, exp);
      else passed++;
      exp = model_next(exp);
      tick();
    end
    start = 1'b0;
    total++;
    if ({tvalid, done, cnt} !== {2'b01, 16'd5})
      $display("FAIL busy_start_done: tvalid=%b done=%b cnt=%0d, want 0 1 5", tvalid, done, cnt);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    tready = 1'b1;
    launch(16'd6, 8'd0, 8'h30);
    tick();
    tick();
    total++;
    if ({tvalid, cnt} !== {1'b1, 16'd2})
      $display("FAIL mid_pre: tvalid=%b cnt=%0d, want 1 2", tvalid, cnt);
    else passed++;
    areset = 1'b1;
    #1;
    total++;
    if ({tvalid, busy, done, cnt} !== {3'b000, 16'd0})
      $display("FAIL mid_async: tvalid=%b busy=%b done=%b cnt=%0d, want 0 0 0 0",
               tvalid, busy, done, cnt);
    else passed++;
    @(posedge aclk);
    #2 areset = 1'b0;
    tick();
    total++;
    if ({tvalid, busy, done} !== 3'b000)
      $display("FAIL mid_release: tvalid=%b busy=%b done=%b, want 0 0 0", tvalid, busy, done);
    else passed++;
    launch(16'd1, 8'd0, 8'h20);
    total++;
    if ({tvalid, tdata} !== {1'b1, model_first(8'h20)})
      $display("FAIL mid_restart: tvalid=%b tdata=%h, want 1 %h", tvalid, tdata, model_first(8'h20));
    else passed++;
    tick();
    total++;
    if ({tvalid, done, cnt} !== {2'b01, 16'd1})
      $display("FAIL mid_restart_done: tvalid=%b done=%b cnt=%0d, want 0 1 1", tvalid, done, cnt);
    else passed++;
    tick();
  endtask

`ifdef AXIS_BYTE_SOURCE_LFSR_EN
  task automatic test_lfsr();
    logic [7:0] seq [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
    tready = 1'b1;
    launch(16'd5, 8'd0, 8'h01);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({tvalid, tdata} !== {1'b1, seq[i]})
        $display("FAIL lfsr_beat%0d: tvalid=%b tdata=%h, want 1 %h", i, tvalid, tdata, seq[i]);
      else passed++;
      tick();
    end
    tick();
    launch(16'd1, 8'd0, 8'h00);
    total++;
    if ({tvalid, tdata} !== {1'b1, 8'h01})
      $display("FAIL lfsr_zero_seed: tvalid=%b tdata=%h, want 1 01", tvalid, tdata);
    else passed++;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_incr_wrap();
    test_backpressure();
    test_gap();
    test_zero_len_and_busy_start();
    test_reset_mid_burst();
`ifdef AXIS_BYTE_SOURCE_LFSR_EN
    test_lfsr();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
